// File: rtl/ula_exec_unit.sv
// ula_exec_unit - ALU execute stage, single-cycle logic/arith, 1-bit/cycle shifter (rev 1.0)
// Optional macro ULA_OVERFLOW_EN adds a registered signed-overflow output.
`default_nettype none

module ula_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
`ifdef ULA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRA  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_LUI  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_SLLV = 4'b1110;
  localparam logic [3:0] OP_SRLV = 4'b1111;

  localparam logic [1:0] DIR_LEFT = 2'd0;
  localparam logic [1:0] DIR_SRL  = 2'd1;
  localparam logic [1:0] DIR_SRA  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg;
  logic [4:0]       cnt;
  logic [1:0]       dir;
  logic             ovf;

  logic [WIDTH-1:0] sum, diff, alu_res, shift_next;
  logic             alu_ill, alu_ovf, is_shift, accept;
  logic [4:0]       shift_cnt;
  logic [1:0]       shift_dir;

  assign accept    = in_valid && in_ready && (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef ULA_OVERFLOW_EN
  assign overflow = ovf;
`endif

  // Single-cycle ops; shift ops pass b through, which is the count-0 result.
  always_comb begin
    alu_res   = '0;
    alu_ill   = 1'b0;
    alu_ovf   = 1'b0;
    is_shift  = 1'b0;
    shift_dir = DIR_LEFT;
    shift_cnt = shamt;
    sum       = a + b;
    diff      = a - b;
    case (operation)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR: alu_res = ~(a | b);
      OP_XOR: alu_res = a ^ b;
      OP_LUI: alu_res = {b[15:0], {(WIDTH-16){1'b0}}};
      OP_SLL: begin
        alu_res  = b;
        is_shift = 1'b1;
      end
      OP_SRL: begin
        alu_res   = b;
        is_shift  = 1'b1;
        shift_dir = DIR_SRL;
      end
      OP_SRA: begin
        alu_res   = b;
        is_shift  = 1'b1;
        shift_dir = DIR_SRA;
      end
      OP_SLLV: begin
        alu_res   = b;
        is_shift  = 1'b1;
        shift_cnt = a[4:0];
      end
      OP_SRLV: begin
        alu_res   = b;
        is_shift  = 1'b1;
        shift_dir = DIR_SRL;
        shift_cnt = a[4:0];
      end
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    shift_next = {shreg[WIDTH-2:0], 1'b0};
    case (dir)
      DIR_SRL: shift_next = {1'b0, shreg[WIDTH-1:1]};
      DIR_SRA: shift_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
      default: shift_next = {shreg[WIDTH-2:0], 1'b0};
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = (is_shift && shift_cnt != 5'd0) ? SHIFT : DONE;
      SHIFT: if (cnt == 5'd1) state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready   <= 1'b1;
      result     <= '0;
      zero       <= 1'b0;
      illegal_op <= 1'b0;
      ovf        <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      dir        <= DIR_LEFT;
    end else begin
      // Registered ready: a new op is accepted only once the FSM is back in IDLE.
      in_ready <= (state_next == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_shift && shift_cnt != 5'd0) begin
              shreg <= b;
              cnt   <= shift_cnt;
              dir   <= shift_dir;
            end else begin
              result     <= alu_res;
              zero       <= (alu_res == '0);
              illegal_op <= alu_ill;
              ovf        <= alu_ovf;
            end
          end
        end
        SHIFT: begin
          shreg <= shift_next;
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            result     <= shift_next;
            zero       <= (shift_next == '0);
            illegal_op <= 1'b0;
            ovf        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
